nic_chan_buf: RTL and testbench
===============================

Name: nic_chan_buf

Overview:
- Parametrised network interface controller between one pipeline node's NIC port (addr_nic/din/dout/nicEn/nicWrEn) and one router port of the CMP mesh/ring.
- Generalises the fixed single-slot NIC with configurable data width, configurable input/output buffer depth, occupancy reporting, a sticky overflow flag and optional virtual-channel (polarity) gating.
- One instance is placed per node in the next-generation parametrised CMP top.

Parameters:
- DATA_W, 64, packet/data word width; bit 0 is the packet MSB and VC bit.
- DEPTH, 4, entries per channel buffer; power of two, at least 2.
- VC_GATE, 1, when 1 the output channel sends only if net_polarity equals head[0]; when 0 polarity is ignored.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr_nic  in  [0:1]  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- din_to_nic  in  [0:DATA_W-1]  processor write data.
- dout_from_nic  out  [0:DATA_W-1]  processor read data.
- nicEn  in  1  access enable.
- nicWrEn  in  1  1 = write, 0 = read; qualified by nicEn.
- net_so  out  1  output channel send request.
- net_ro  in  1  router ready to accept.
- net_do  out  [0:DATA_W-1]  output packet (head of output buffer).
- net_si  in  1  router send into input channel.
- net_ri  out  1  NIC input channel ready.
- net_di  in  [0:DATA_W-1]  input packet.
- net_polarity  in  1  router cycle polarity (even/odd VC phase).

Behaviour:
- Reset (reset=0, asynchronous): both buffers empty, pointers and counts 0, storage 0, overflow flag 0.
- Outputs in reset: net_so=0, net_ri=1, net_do=0, dout_from_nic=0.
- Buffers are circular FIFOs. Pointers wrap modulo DEPTH. Count is 0..DEPTH. Full means count==DEPTH.
- Processor reads are combinational, with no latency:
  - 00 returns input head.
  - 01 returns status: bit DATA_W-1 = input non-empty; bits [DATA_W-1-CNT_W:DATA_W-2] = input count; all other bits 0.
  - 11 returns status: bit DATA_W-1 = output full; bit DATA_W-2 = overflow; bits [DATA_W-2-CNT_W:DATA_W-3] = output count; all other bits 0.
  - 10 read returns 0.
  - dout_from_nic = 0 whenever nicEn=0 or nicWrEn=1.
- Pop: a read of 00 with the input buffer non-empty pops the head at the clock edge. A read of 00 when empty returns the stale head entry, does not pop, and leaves state unchanged.
- Push: a write to 10 pushes din_to_nic at the edge if the output buffer is not full. A write when full is dropped and sets overflow.
- Overflow is sticky; it clears at the edge of a read of 11. If a clear and a new drop occur in the same cycle, the set wins.
- Writes to 00, 01 and 11 are ignored.
- Input channel:
  - net_ri = ~input_full, derived from registered state only (no combinational path from net_si or processor signals).
  - A push occurs when net_si & net_ri. net_si while full is ignored (router protocol violation; no state change).
- Output channel:
  - net_so = output non-empty & (VC_GATE==0 | net_polarity==head[0]).
  - net_do = output head entry (the reset value 0 when never written).
  - A transfer occurs when net_so & net_ro and pops the head at the edge.
- Simultaneous events:
  - Router push and processor pop on the input buffer in the same cycle: both occur and count is unchanged. Pop of an empty buffer plus a push: only the push occurs.
  - Processor push and router pop on the output buffer in the same cycle: both occur. When full, the push is still dropped because fullness is evaluated on pre-edge state.
- Reset asserted mid-transfer discards all buffered packets immediately; no partial state survives.

Test Plan:
- Reset, then read 01 and 11 -> dout_from_nic=0 for both; net_ri=1; net_so=0.
- Router pushes 0x...01, 0x...02, 0x...03, 0x...04 (DEPTH=4) -> net_ri falls to 0 after the 4th; 01 reads bit63=1 with count=4; four reads of 00 return 01,02,03,04 in order; count returns to 0.
- Processor writes 5 words to 10 with net_ro=0 -> 11 reads full=1, overflow=1, count=4. A second read of 11 shows overflow=0. The 5th word never appears on net_do.
- VC_GATE=1: head word with bit0=1, net_ro=1, net_polarity=0 -> net_so=0; toggle net_polarity=1 -> net_so=1, word transferred in 1 cycle, count decrements.
- Same-cycle router push and processor pop with input count=2 -> count stays 2 and FIFO order is preserved. Repeat with output full plus a simultaneous processor write and router pop -> count goes 4→3 and overflow=1.
- Assert reset while both buffers hold 3 entries -> net_so=0, net_ri=1 and all counts 0 with no clock edge required.

Source files
------------

// File: rtl/nic_chan_buf.sv
// ============================================================================
// nic_chan_buf : parametrised NIC with input/output circular FIFOs between a
//                processor port and a router port, with optional VC gating.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module nic_chan_buf #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int VC_GATE = 1,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:1]        addr_nic,
  input  logic [0:DATA_W-1] din_to_nic,
  output logic [0:DATA_W-1] dout_from_nic,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  input  logic              net_polarity
);

  localparam int AW = $clog2(DEPTH);

  logic [0:DATA_W-1] r_in_mem  [DEPTH];
  logic [0:DATA_W-1] r_out_mem [DEPTH];
  logic [AW-1:0]     r_in_wr, r_in_rd, r_out_wr, r_out_rd;
  logic [CNT_W-1:0]  r_in_cnt, r_out_cnt;
  logic              r_ovf;

  logic              w_rd, w_wr;
  logic              w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic              w_in_push, w_in_pop, w_out_push, w_out_pop;
  logic              w_out_drop, w_ovf_clr, w_vc_ok;
  logic [0:DATA_W-1] w_in_head, w_out_head;
  logic [DATA_W-1:0] w_in_stat, w_out_stat;
  logic [0:DATA_W-1] w_dout;

  assign w_rd = nicEn & ~nicWrEn;
  assign w_wr = nicEn & nicWrEn;

  assign w_in_full   = (r_in_cnt  == CNT_W'(DEPTH));
  assign w_in_empty  = (r_in_cnt  == '0);
  assign w_out_full  = (r_out_cnt == CNT_W'(DEPTH));
  assign w_out_empty = (r_out_cnt == '0);

  assign w_in_head  = r_in_mem[r_in_rd];
  assign w_out_head = r_out_mem[r_out_rd];

  generate
    if (VC_GATE != 0) begin : g_vc_gate
      assign w_vc_ok = (net_polarity == w_out_head[0]);
    end else begin : g_no_vc_gate
      assign w_vc_ok = 1'b1;
    end
  endgenerate

  // Full/empty come from pre-edge state, so simultaneous push+pop never
  // lets a push into a full buffer through.
  assign w_in_push  = net_si & ~w_in_full;
  assign w_in_pop   = w_rd & (addr_nic == 2'b00) & ~w_in_empty;
  assign w_out_push = w_wr & (addr_nic == 2'b10) & ~w_out_full;
  assign w_out_drop = w_wr & (addr_nic == 2'b10) & w_out_full;
  assign w_out_pop  = net_so & net_ro;
  assign w_ovf_clr  = w_rd & (addr_nic == 2'b11);

  assign net_ri = ~w_in_full;
  assign net_so = ~w_out_empty & w_vc_ok;
  assign net_do = w_out_head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_in_mem[i] <= '0;
      r_in_wr  <= '0;
      r_in_rd  <= '0;
      r_in_cnt <= '0;
    end else begin
      if (w_in_push) begin
        r_in_mem[r_in_wr] <= net_di;
        r_in_wr           <= r_in_wr + AW'(1);
      end
      if (w_in_pop) r_in_rd <= r_in_rd + AW'(1);
      r_in_cnt <= r_in_cnt + CNT_W'(w_in_push) - CNT_W'(w_in_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_out_mem[i] <= '0;
      r_out_wr  <= '0;
      r_out_rd  <= '0;
      r_out_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_out_push) begin
        r_out_mem[r_out_wr] <= din_to_nic;
        r_out_wr            <= r_out_wr + AW'(1);
      end
      if (w_out_pop) r_out_rd <= r_out_rd + AW'(1);
      r_out_cnt <= r_out_cnt + CNT_W'(w_out_push) - CNT_W'(w_out_pop);
      if (w_out_drop)     r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  // Status words built LSB-numbered; the last bit of the ascending bus is bit 0 here.
  always_comb begin
    w_in_stat              = '0;
    w_in_stat[0]           = ~w_in_empty;
    w_in_stat[CNT_W:1]     = r_in_cnt;
    w_out_stat             = '0;
    w_out_stat[0]          = w_out_full;
    w_out_stat[1]          = r_ovf;
    w_out_stat[CNT_W+1:2]  = r_out_cnt;
  end

  always_comb begin
    w_dout = '0;
    if (w_rd) begin
      case (addr_nic)
        2'b00:   w_dout = w_in_head;
        2'b01:   w_dout = w_in_stat;
        2'b11:   w_dout = w_out_stat;
        default: w_dout = '0;
      endcase
    end
  end

  assign dout_from_nic = w_dout;

endmodule

`default_nettype wire

// File: tb/tb_nic_chan_buf.sv
// ============================================================================
// tb_nic_chan_buf : directed + random bench for nic_chan_buf against a
//                   queue-based reference model.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_nic_chan_buf;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [0:1]        addr_nic;
  logic [0:DATA_W-1] din_to_nic, dout_from_nic, net_do, net_di;
  logic              nicEn, nicWrEn, net_so, net_ro, net_si, net_ri, net_polarity;

  int n_vec = 0;
  int n_bad = 0;

  nic_chan_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .VC_GATE(1)) dut (
    .clk(clk), .reset(reset), .addr_nic(addr_nic), .din_to_nic(din_to_nic),
    .dout_from_nic(dout_from_nic), .nicEn(nicEn), .nicWrEn(nicWrEn),
    .net_so(net_so), .net_ro(net_ro), .net_do(net_do), .net_si(net_si),
    .net_ri(net_ri), .net_di(net_di), .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  // Reference model: queues for contents, shadow arrays for stale heads.
  logic [0:DATA_W-1] in_q[$], out_q[$];
  logic [0:DATA_W-1] in_mem[DEPTH], out_mem[DEPTH];
  int                in_pushes, in_pops, out_pushes, out_pops;
  bit                ovf;

  function automatic void model_reset();
    in_q.delete(); out_q.delete();
    for (int i = 0; i < DEPTH; i++) begin in_mem[i] = '0; out_mem[i] = '0; end
    in_pushes = 0; in_pops = 0; out_pushes = 0; out_pops = 0; ovf = 0;
  endfunction

  function automatic logic [0:DATA_W-1] in_head();
    return (in_q.size() > 0) ? in_q[0] : in_mem[in_pops % DEPTH];
  endfunction

  function automatic logic [0:DATA_W-1] out_head();
    return (out_q.size() > 0) ? out_q[0] : out_mem[out_pops % DEPTH];
  endfunction

  function automatic bit exp_so();
    logic [0:DATA_W-1] h;
    h = out_head();
    return (out_q.size() > 0) && (h[0] == net_polarity);
  endfunction

  function automatic logic [63:0] exp_dout();
    int in_n, out_n;
    in_n  = in_q.size();
    out_n = out_q.size();
    if (!(nicEn && !nicWrEn)) return 64'd0;
    case (addr_nic)
      2'b00:   return in_head();
      2'b01:   return 64'(in_n) * 2 + ((in_n != 0) ? 64'd1 : 64'd0);
      2'b11:   return 64'(out_n) * 4 + (ovf ? 64'd2 : 64'd0)
                      + ((out_n == DEPTH) ? 64'd1 : 64'd0);
      default: return 64'd0;
    endcase
  endfunction

  function automatic void model_step();
    bit rd, wr, ip, ipush, op, owr, clr;
    rd    = nicEn && !nicWrEn;
    wr    = nicEn && nicWrEn;
    ip    = rd && addr_nic == 2'b00 && in_q.size() > 0;
    ipush = net_si && in_q.size() < DEPTH;
    op    = exp_so() && net_ro;
    owr   = wr && addr_nic == 2'b10;
    clr   = rd && addr_nic == 2'b11;
    if (owr && out_q.size() == DEPTH) ovf = 1;
    else if (clr)                     ovf = 0;
    if (owr && out_q.size() < DEPTH) begin
      out_q.push_back(din_to_nic);
      out_mem[out_pushes % DEPTH] = din_to_nic;
      out_pushes++;
    end
    if (op) begin void'(out_q.pop_front()); out_pops++; end
    if (ipush) begin
      in_q.push_back(net_di);
      in_mem[in_pushes % DEPTH] = net_di;
      in_pushes++;
    end
    if (ip) begin void'(in_q.pop_front()); in_pops++; end
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("net_ri", 64'(net_ri), (in_q.size() < DEPTH) ? 64'd1 : 64'd0);
    chk("net_so", 64'(net_so), exp_so() ? 64'd1 : 64'd0);
    chk("net_do", net_do, out_head());
    chk("dout",   dout_from_nic, exp_dout());
  end

  task automatic tick();
    @(posedge clk);
    if (reset) model_step(); else model_reset();
    #1;
  endtask

  task automatic idle();
    nicEn = 0; nicWrEn = 0; addr_nic = 2'b00; din_to_nic = '0;
    net_si = 0; net_di = '0; net_ro = 0;
  endtask

  task automatic proc_rd(input logic [0:1] a);
    nicEn = 1; nicWrEn = 0; addr_nic = a;
  endtask

  task automatic proc_wr(input logic [0:1] a, input logic [0:DATA_W-1] d);
    nicEn = 1; nicWrEn = 1; addr_nic = a; din_to_nic = d;
  endtask

  logic [0:DATA_W-1] w [1:5];

  initial begin
    model_reset();
    idle();
    net_polarity = 0;
    reset = 0;
    #2;
    chk("rst_ri", 64'(net_ri), 64'd1);
    chk("rst_so", 64'(net_so), 64'd0);
    chk("rst_do", net_do, 64'd0);
    tick(); tick();
    reset = 1;

    // status reads after reset
    proc_rd(2'b01); #1 chk("stat_in_rst", dout_from_nic, 64'd0);
    proc_rd(2'b11); #1 chk("stat_out_rst", dout_from_nic, 64'd0);
    tick();

    // router fills input buffer, processor drains it in order
    idle();
    for (int k = 1; k <= 4; k++) begin net_si = 1; net_di = 64'(k); tick(); end
    net_si = 0;
    #1 chk("ri_full", 64'(net_ri), 64'd0);
    proc_rd(2'b01); #1 chk("stat_in_full", dout_from_nic, 64'h9);
    for (int k = 1; k <= 4; k++) begin
      proc_rd(2'b00); #1 chk("pop_order", dout_from_nic, 64'(k));
      tick();
    end
    proc_rd(2'b01); #1 chk("stat_in_empty", dout_from_nic, 64'h0);
    tick();

    // output overflow
    w[1] = 64'h8000_0000_0000_0011; w[2] = 64'h22; w[3] = 64'h33;
    w[4] = 64'h44; w[5] = 64'h55;
    for (int k = 1; k <= 5; k++) begin proc_wr(2'b10, w[k]); tick(); end
    proc_rd(2'b11); #1 chk("stat_out_ovf", dout_from_nic, 64'h13);
    tick();
    proc_rd(2'b11); #1 chk("stat_out_clr", dout_from_nic, 64'h11);
    chk("do_head1", net_do, w[1]);
    tick();

    // VC gating
    idle(); net_ro = 1; net_polarity = 0;
    #1 chk("vc_block", 64'(net_so), 64'd0);
    tick();
    net_polarity = 1;
    #1 chk("vc_pass", 64'(net_so), 64'd1);
    tick();
    net_ro = 0; proc_rd(2'b11);
    #1 chk("stat_out_3", dout_from_nic, 64'hC);
    chk("do_head2", net_do, w[2]);
    chk("vc_block2", 64'(net_so), 64'd0);
    tick();

    // simultaneous push+pop on input
    idle();
    net_si = 1; net_di = 64'h101; tick();
    net_di = 64'h102; tick();
    net_di = 64'h103; proc_rd(2'b00);
    #1 chk("sim_pop", dout_from_nic, 64'h101);
    tick();
    net_si = 0; proc_rd(2'b01);
    #1 chk("sim_cnt", dout_from_nic, 64'h5);
    tick();
    proc_rd(2'b00); #1 chk("sim_ord1", dout_from_nic, 64'h102); tick();
    proc_rd(2'b00); #1 chk("sim_ord2", dout_from_nic, 64'h103); tick();

    // full output: simultaneous write (dropped) and router pop
    idle(); proc_wr(2'b10, 64'h66); tick();
    net_polarity = 0; net_ro = 1; proc_wr(2'b10, 64'h77);
    #1 chk("full_so", 64'(net_so), 64'd1);
    tick();
    net_ro = 0; proc_rd(2'b11);
    #1 chk("full_pop_ovf", dout_from_nic, 64'hE);
    tick();
    idle();
    #1 chk("do_head3", net_do, w[3]);

    // asynchronous reset with both buffers at 3 entries
    for (int k = 1; k <= 3; k++) begin net_si = 1; net_di = 64'h200 + 64'(k); tick(); end
    net_si = 0;
    #1 chk("pre_rst_so", 64'(net_so), 64'd1);
    #2 reset = 0; model_reset();
    #1 chk("arst_so", 64'(net_so), 64'd0);
    chk("arst_ri", 64'(net_ri), 64'd1);
    chk("arst_do", net_do, 64'd0);
    proc_rd(2'b01); #1 chk("arst_in", dout_from_nic, 64'd0);
    proc_rd(2'b11); #1 chk("arst_out", dout_from_nic, 64'd0);
    proc_rd(2'b00); #1 chk("arst_head", dout_from_nic, 64'd0);
    tick();
    reset = 1; idle();
    tick();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      nicEn        = ($urandom_range(0, 9) < 7);
      nicWrEn      = $urandom_range(0, 1);
      addr_nic     = 2'($urandom_range(0, 3));
      din_to_nic   = {$urandom, $urandom};
      net_si       = $urandom_range(0, 1);
      net_di       = {$urandom, $urandom};
      net_ro       = ($urandom_range(0, 3) != 0);
      net_polarity = $urandom_range(0, 1);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 0; model_reset();
        #1 reset = 1;
      end
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
